// File: rtl/phy_tx_lane_serializer_c.sv
// rtl/phy_tx_lane_serializer_c.sv - two-lane TX PHY serializer: word striping, pairing and MSB-first framing
//
// Ports:
//   clk_32f          in   1   serial bit clock (only clock)
//   reset            in   1   synchronous, active-low reset
//   valid_in         in   1   Data_in holds a word to send
//   Data_in          in   32  transmit word
//   ready_out        out  1   block accepts a word this cycle
//   Data_out_0       out  1   lane 0 serial bit (even words)
//   Data_out_1       out  1   lane 1 serial bit (odd words)
//   frame_start_out  out  1   high in bit 0 of every frame
//   data_frame_out   out  1   high for a whole frame that carries data rather than COM
//
// Optional feature macro: PHY_TX_PREAMBLE_EN
//   When defined, PREAMBLE_FRAMES COM frames are forced after reset with ready_out held low.

module phy_tx_lane_serializer_c #(
    parameter logic [7:0] COM_SYM = 8'hBC
`ifdef PHY_TX_PREAMBLE_EN
    ,
    parameter int PREAMBLE_FRAMES = 4
`endif
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] Data_in,
    output logic        ready_out,
    output logic        Data_out_0,
    output logic        Data_out_1,
    output logic        frame_start_out,
    output logic        data_frame_out
);

    localparam logic [31:0] COM_FRAME = {4{COM_SYM}};

    logic [4:0]  bit_cnt;
    logic        sel;
    logic        f0;
    logic        f1;
    logic [31:0] hold0;
    logic [31:0] hold1;
    logic [31:0] shift0;
    logic [31:0] shift1;
    logic        data_frame_q;
    logic        preamble;

    logic        boundary;
    logic        xfer;
    logic        load_pair;

    assign boundary  = (bit_cnt == 5'd31);
    assign ready_out = !(sel ? f1 : f0) && !preamble && reset;
    assign xfer      = valid_in && ready_out;
    // Pair completeness is judged on pre-edge flags, so a pair finished on
    // the boundary edge itself waits for the following frame.
    assign load_pair = boundary && f0 && f1;

    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            bit_cnt      <= 5'd0;
            sel          <= 1'b0;
            f0           <= 1'b0;
            f1           <= 1'b0;
            hold0        <= 32'd0;
            hold1        <= 32'd0;
            shift0       <= COM_FRAME;
            shift1       <= COM_FRAME;
            data_frame_q <= 1'b0;
        end else begin
            bit_cnt <= bit_cnt + 5'd1;

            if (xfer) begin
                sel <= ~sel;
                if (sel) begin
                    hold1 <= Data_in;
                end else begin
                    hold0 <= Data_in;
                end
            end

            // ready_out is low whenever both flags are set, so a load and a
            // transfer never touch the same flag on one edge.
            f0 <= (f0 && !load_pair) || (xfer && !sel);
            f1 <= (f1 && !load_pair) || (xfer && sel);

            if (boundary) begin
                // A lone held word stays put: lanes only ever carry data in pairs,
                // which keeps word order intact at the receiver.
                shift0       <= load_pair ? hold0 : COM_FRAME;
                shift1       <= load_pair ? hold1 : COM_FRAME;
                data_frame_q <= load_pair;
            end else begin
                shift0 <= {shift0[30:0], 1'b0};
                shift1 <= {shift1[30:0], 1'b0};
            end
        end
    end

`ifdef PHY_TX_PREAMBLE_EN
    logic [2:0] pre_cnt;

    // Counts frame boundaries after reset; preamble drops at the boundary
    // that ends frame PREAMBLE_FRAMES.
    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            pre_cnt  <= 3'd0;
            preamble <= 1'b1;
        end else if (boundary && preamble) begin
            pre_cnt <= pre_cnt + 3'd1;
            if (pre_cnt == 3'(PREAMBLE_FRAMES - 1)) begin
                preamble <= 1'b0;
            end
        end
    end
`else
    assign preamble = 1'b0;
`endif

    assign Data_out_0      = shift0[31];
    assign Data_out_1      = shift1[31];
    assign frame_start_out = (bit_cnt == 5'd0);
    assign data_frame_out  = data_frame_q;

endmodule

// File: tb/tb_phy_tx_lane_serializer_c.sv
// tb/tb_phy_tx_lane_serializer_c.sv - scoreboard bench for phy_tx_lane_serializer_c

module tb_phy_tx_lane_serializer_c;

    logic        clk_32f = 1'b0;
    logic        reset = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] Data_in = 32'd0;
    logic        ready_out;
    logic        Data_out_0;
    logic        Data_out_1;
    logic        frame_start_out;
    logic        data_frame_out;

    phy_tx_lane_serializer_c dut (
        .clk_32f        (clk_32f),
        .reset          (reset),
        .valid_in       (valid_in),
        .Data_in        (Data_in),
        .ready_out      (ready_out),
        .Data_out_0     (Data_out_0),
        .Data_out_1     (Data_out_1),
        .frame_start_out(frame_start_out),
        .data_frame_out (data_frame_out)
    );

    always #5 clk_32f = ~clk_32f;

    typedef struct {
        logic [31:0] l0;
        logic [31:0] l1;
        int          frame;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          data_frames = 0;
    int          tb_cnt = 0;
    int          tb_frame = 0;
    logic [31:0] pend = 32'd0;
    bit          par = 1'b0;

    // Reference bit/frame position: frames are 32 cycles from reset release.
    always @(posedge clk_32f) begin
        if (!reset) begin
            tb_cnt   <= 0;
            tb_frame <= 0;
        end else begin
            tb_cnt <= (tb_cnt + 1) % 32;
            if (tb_cnt == 31) tb_frame <= tb_frame + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: captures each frame on both lanes and compares at its last bit.
    logic [31:0] cap0 = 32'd0;
    logic [31:0] cap1 = 32'd0;
    logic        cap_on = 1'b0;
    logic        cap_df = 1'b0;

    always @(negedge clk_32f) begin
        exp_t e;
        if (!reset) begin
            cap_on = 1'b0;
        end else begin
            check("frame_start", {31'd0, frame_start_out}, {31'd0, tb_cnt == 0});
            if (tb_cnt == 0) begin
                cap_on = 1'b1;
                cap_df = data_frame_out;
            end
            if (cap_on) begin
                check("data_frame_stable", {31'd0, data_frame_out}, {31'd0, cap_df});
                cap0 = {cap0[30:0], Data_out_0};
                cap1 = {cap1[30:0], Data_out_1};
                if (tb_cnt == 31) begin
                    cap_on = 1'b0;
                    if (cap_df) begin
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_data_frame: got %h/%h expected COM frame", cap0, cap1);
                        end else begin
                            e = exp_q.pop_front();
                            data_frames++;
                            check("lane0_data", cap0, e.l0);
                            check("lane1_data", cap1, e.l1);
                            check("data_frame_no", tb_frame, e.frame);
                        end
                    end else begin
                        check("lane0_com", cap0, 32'hBCBCBCBC);
                        check("lane1_com", cap1, 32'hBCBCBCBC);
                    end
                end
            end
        end
    end

    task automatic do_reset(input int n);
        reset = 1'b0;
        valid_in = 1'b0;
        exp_q.delete();
        par = 1'b0;
        @(posedge clk_32f);
        repeat (n) begin
            @(negedge clk_32f);
            check("rst_out0", {31'd0, Data_out_0}, 32'd1);
            check("rst_out1", {31'd0, Data_out_1}, 32'd1);
            check("rst_ready", {31'd0, ready_out}, 32'd0);
            check("rst_data_frame", {31'd0, data_frame_out}, 32'd0);
            check("rst_frame_start", {31'd0, frame_start_out}, 32'd1);
        end
        @(posedge clk_32f);
        #1 reset = 1'b1;
`ifdef PHY_TX_PREAMBLE_EN
        repeat (128) begin
            @(negedge clk_32f);
            check("preamble_ready", {31'd0, ready_out}, 32'd0);
        end
`else
        @(negedge clk_32f);
        check("ready_after_reset", {31'd0, ready_out}, 32'd1);
`endif
    endtask

    // at_cnt >= 0 presents the word only in the cycle where bit_cnt == at_cnt.
    task automatic send_word(input logic [31:0] d, input int at_cnt);
        int c = 0;
        int f = 0;
        bit done = 1'b0;
        exp_t e;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk_32f);
            if (at_cnt < 0 || tb_cnt == at_cnt) begin
                valid_in = 1'b1;
                Data_in  = d;
                if (ready_out) begin
                    c = tb_cnt;
                    f = tb_frame;
                    @(posedge clk_32f);
                    #1 valid_in = 1'b0;
                    done = 1'b1;
                end
            end else begin
                valid_in = 1'b0;
            end
        end
        if (!done) begin
            valid_in = 1'b0;
            total++;
            bad++;
            $display("FAIL send_timeout: got no handshake expected one for word %h", d);
        end else if (!par) begin
            pend = d;
            par  = 1'b1;
            @(negedge clk_32f);
            check("ready_mid_pair", {31'd0, ready_out}, 32'd1);
        end else begin
            par     = 1'b0;
            e.l0    = pend;
            e.l1    = d;
            e.frame = (c == 31) ? f + 2 : f + 1;
            exp_q.push_back(e);
            @(negedge clk_32f);
            check("ready_after_pair", {31'd0, ready_out}, 32'd0);
        end
    endtask

    task automatic drain();
        int i = 0;
        while (exp_q.size() != 0 && i < 400) begin
            @(negedge clk_32f);
            i++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending pairs expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_pos(input int frame, input int cnt);
        int i = 0;
        while (!(tb_frame == frame && tb_cnt == cnt) && i < 300) begin
            @(negedge clk_32f);
            i++;
        end
        if (i >= 300) begin
            total++;
            bad++;
            $display("FAIL wait_pos_timeout: got frame %0d bit %0d expected frame %0d bit %0d",
                     tb_frame, tb_cnt, frame, cnt);
        end
    endtask

    initial begin
        logic [31:0] words[8];
        int          fx;
        words = '{32'h00000001, 32'h10000002, 32'h20000003, 32'h30000004,
                  32'h40000005, 32'h50000006, 32'h60000007, 32'h70000008};

        do_reset(5);
        repeat (96) @(negedge clk_32f);

        send_word(32'hDEADBEEF, -1);
        send_word(32'h01234567, -1);
        drain();

        send_word(32'hAAAA5555, -1);
        repeat (100) @(negedge clk_32f);
        send_word(32'h0F0F0F0F, -1);
        drain();

        for (int i = 0; i < 8; i++) send_word(words[i], -1);
        drain();

        send_word(32'h11111111, -1);
        send_word(32'h22222222, 31);
        drain();

        send_word(32'hCAFEF00D, -1);
        send_word(32'h5A5AA5A5, -1);
        fx = (exp_q.size() != 0) ? exp_q[0].frame : tb_frame + 1;
        wait_pos(fx, 1);
        send_word(32'h33333333, -1);
        wait_pos(fx, 15);
        do_reset(3);
        send_word(32'h44444444, -1);
        send_word(32'h55555555, -1);
        drain();
        repeat (40) @(negedge clk_32f);

        check("queue_empty", exp_q.size(), 32'd0);
        check("data_frame_count", data_frames, 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
